park_gate_counter: RTL and testbench

PARK_GATE_COUNTER -- requirements
Module: park_gate_counter

---
 rtl/park_gate_counter.sv | 251 +++++++++++++++++++++++++
 tb/tb_park_gate_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/park_gate_counter.sv
// ----------------------------------------------------------------------------
// park_gate_counter
//
// Tracks car park occupancy from NUM_GATES independent two-beam gates. Each
// gate has an outer beam (a) and an inner beam (b). A car entering breaks
// them in the order a, a+b, b, none. A car leaving breaks them in the
// reverse order. A per-gate FSM follows these sequences. It holds while the
// code stays the same. It steps back one state on a single-step reversal.
// Any other code drops it back to IDLE. Completed passes from all gates are
// combined into one occupancy update each cycle. Passes that would take the
// count past CAPACITY or below zero are refused, starting from the highest
// gate index.
//
// Optional feature (compile-time macro PARK_GATE_ERR_EN):
//   When defined, the port gate_err and its logic are present. The port
//   gives a one-cycle pulse for each illegal sensor transition on a gate.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   sens_a       in   [NUM_GATES] outer beam per gate, 1 = blocked
//   sens_b       in   [NUM_GATES] inner beam per gate, 1 = blocked
//   count        out  [CNT_W]     registered occupancy
//   full         out  count == CAPACITY
//   empty        out  count == 0
//   entry_pulse  out  [NUM_GATES] accepted entry, one cycle
//   exit_pulse   out  [NUM_GATES] accepted exit, one cycle
//   reject_pulse out  [NUM_GATES] completed pass refused at a limit
//   gate_err     out  [NUM_GATES] illegal transition (PARK_GATE_ERR_EN only)
// ----------------------------------------------------------------------------
module park_gate_counter #(
    parameter int NUM_GATES = 2,
    parameter int CNT_W     = 6,
    parameter int CAPACITY  = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] sens_a,
    input  logic [NUM_GATES-1:0] sens_b,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] entry_pulse,
    output logic [NUM_GATES-1:0] exit_pulse,
    output logic [NUM_GATES-1:0] reject_pulse
`ifdef PARK_GATE_ERR_EN
    ,
    output logic [NUM_GATES-1:0] gate_err
`endif
);

    // Headroom for count + up to 8 entries - up to 8 exits, kept signed.
    localparam int SW = CNT_W + 4;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } gate_state_t;

    gate_state_t state_q [NUM_GATES];
    gate_state_t state_d [NUM_GATES];
    logic [1:0]  code    [NUM_GATES];

    logic [NUM_GATES-1:0] entry_done;
    logic [NUM_GATES-1:0] exit_done;
    logic [NUM_GATES-1:0] entry_acc;
    logic [NUM_GATES-1:0] exit_acc;
    logic [NUM_GATES-1:0] reject_d;
    logic [3:0]           e_cnt;
    logic [3:0]           x_cnt;
    logic [3:0]           rej_left;
    logic signed [SW-1:0] sum_s;
    logic [CNT_W-1:0]     count_d;

    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            code[g] = {sens_a[g], sens_b[g]};
        end
    end

    // ---------------------------------------------------------------
    // Process 1: per-gate state register
    // ---------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NUM_GATES; g++) begin
            if (reset) state_q[g] <= IDLE;
            else       state_q[g] <= state_d[g];
        end
    end

    // ---------------------------------------------------------------
    // Process 2: next-state logic
    // Forward step, hold on own code, one-step backtrack, else IDLE.
    // ---------------------------------------------------------------
    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            // NOTE: a default before the case keeps every path assigned, so no
            // latch is inferred for unlisted codes or the unused encoding.
            state_d[g] = IDLE;
            case (state_q[g])
                IDLE: case (code[g])
                          2'b10:   state_d[g] = EN1;
                          2'b01:   state_d[g] = EX1;
                          default: state_d[g] = IDLE;
                      endcase
                EN1:  case (code[g])
                          2'b10:   state_d[g] = EN1;
                          2'b11:   state_d[g] = EN2;
                          default: state_d[g] = IDLE;
                      endcase
                EN2:  case (code[g])
                          2'b11:   state_d[g] = EN2;
                          2'b01:   state_d[g] = EN3;
                          2'b10:   state_d[g] = EN1;
                          default: state_d[g] = IDLE;
                      endcase
                EN3:  case (code[g])
                          2'b01:   state_d[g] = EN3;
                          2'b11:   state_d[g] = EN2;
                          default: state_d[g] = IDLE;
                      endcase
                EX1:  case (code[g])
                          2'b01:   state_d[g] = EX1;
                          2'b11:   state_d[g] = EX2;
                          default: state_d[g] = IDLE;
                      endcase
                EX2:  case (code[g])
                          2'b11:   state_d[g] = EX2;
                          2'b10:   state_d[g] = EX3;
                          2'b01:   state_d[g] = EX1;
                          default: state_d[g] = IDLE;
                      endcase
                EX3:  case (code[g])
                          2'b10:   state_d[g] = EX3;
                          2'b11:   state_d[g] = EX2;
                          default: state_d[g] = IDLE;
                      endcase
                default: state_d[g] = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Process 3: per-gate decode of completions (and illegal codes)
    // ---------------------------------------------------------------
`ifdef PARK_GATE_ERR_EN
    logic [NUM_GATES-1:0] illegal;
`endif

    always_comb begin
        for (int g = 0; g < NUM_GATES; g++) begin
            entry_done[g] = (state_q[g] == EN3) && (code[g] == 2'b00);
            exit_done[g]  = (state_q[g] == EX3) && (code[g] == 2'b00);
`ifdef PARK_GATE_ERR_EN
            // Each state has exactly one code that is neither a hold, a
            // forward step nor a backtrack.
            case (state_q[g])
                IDLE:    illegal[g] = (code[g] == 2'b11);
                EN1:     illegal[g] = (code[g] == 2'b01);
                EN2:     illegal[g] = (code[g] == 2'b00);
                EN3:     illegal[g] = (code[g] == 2'b10);
                EX1:     illegal[g] = (code[g] == 2'b10);
                EX2:     illegal[g] = (code[g] == 2'b00);
                EX3:     illegal[g] = (code[g] == 2'b01);
                default: illegal[g] = 1'b1;
            endcase
`endif
        end
    end

    // ---------------------------------------------------------------
    // Occupancy arbitration: apply count + E - X and clamp at either limit.
    // The excess passes are refused from the highest gate index down.
    // ---------------------------------------------------------------
    always_comb begin
        e_cnt    = '0;
        x_cnt    = '0;
        rej_left = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            e_cnt = e_cnt + {3'b000, entry_done[g]};
            x_cnt = x_cnt + {3'b000, exit_done[g]};
        end

        sum_s = $signed({4'b0000, count})
              + $signed({{CNT_W{1'b0}}, e_cnt})
              - $signed({{CNT_W{1'b0}}, x_cnt});

        entry_acc = entry_done;
        exit_acc  = exit_done;
        reject_d  = '0;
        count_d   = sum_s[CNT_W-1:0];

        if (sum_s > CAP_S) begin
            rej_left = 4'(sum_s - CAP_S);
            count_d  = CNT_W'(CAPACITY);
            for (int g = NUM_GATES - 1; g >= 0; g--) begin
                if (entry_done[g] && rej_left != 4'd0) begin
                    entry_acc[g] = 1'b0;
                    reject_d[g]  = 1'b1;
                    rej_left     = rej_left - 4'd1;
                end
            end
        end else if (sum_s[SW-1]) begin
            rej_left = 4'(-sum_s);
            count_d  = '0;
            for (int g = NUM_GATES - 1; g >= 0; g--) begin
                if (exit_done[g] && rej_left != 4'd0) begin
                    exit_acc[g] = 1'b0;
                    reject_d[g] = 1'b1;
                    rej_left    = rej_left - 4'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Registered outputs. Reset wins over any completion on the same edge.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            entry_pulse  <= '0;
            exit_pulse   <= '0;
            reject_pulse <= '0;
        end else begin
            count        <= count_d;
            entry_pulse  <= entry_acc;
            exit_pulse   <= exit_acc;
            reject_pulse <= reject_d;
        end
    end

`ifdef PARK_GATE_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) gate_err <= '0;
        else       gate_err <= illegal;
    end
`endif

    assign full  = (count == CNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_park_gate_counter.sv
// ----------------------------------------------------------------------------
// tb_park_gate_counter
//
// Directed bench for park_gate_counter. The main instance uses the default
// parameters. A second instance with CAPACITY=3 covers simultaneous passes
// at the limit. Inputs are driven 1 time unit after a rising edge. Outputs
// are read at the same point, so each read reflects the edge just taken.
// ----------------------------------------------------------------------------
module tb_park_gate_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sens_a,  sens_b;
    logic [1:0] sens_a3, sens_b3;

    logic [5:0] count,  count3;
    logic       full,   empty,  full3, empty3;
    logic [1:0] entry_pulse,  exit_pulse,  reject_pulse;
    logic [1:0] entry_pulse3, exit_pulse3, reject_pulse3;
`ifdef PARK_GATE_ERR_EN
    logic [1:0] gate_err, gate_err3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    park_gate_counter u_dut (
        .clk          (clk),
        .reset        (reset),
        .sens_a       (sens_a),
        .sens_b       (sens_b),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .reject_pulse (reject_pulse)
`ifdef PARK_GATE_ERR_EN
        ,
        .gate_err     (gate_err)
`endif
    );

    park_gate_counter #(.NUM_GATES(2), .CNT_W(6), .CAPACITY(3)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .sens_a       (sens_a3),
        .sens_b       (sens_b3),
        .count        (count3),
        .full         (full3),
        .empty        (empty3),
        .entry_pulse  (entry_pulse3),
        .exit_pulse   (exit_pulse3),
        .reject_pulse (reject_pulse3)
`ifdef PARK_GATE_ERR_EN
        ,
        .gate_err     (gate_err3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one gate's {a,b} code on the selected instance, then take an edge.
    task automatic drive(input bit sel3, input int g, input logic [1:0] c);
        if (sel3) begin
            sens_a3[g] = c[1];
            sens_b3[g] = c[0];
        end else begin
            sens_a[g] = c[1];
            sens_b[g] = c[0];
        end
        tick();
    endtask

    task automatic entry_pass(input bit sel3, input int g);
        drive(sel3, g, 2'b10);
        drive(sel3, g, 2'b11);
        drive(sel3, g, 2'b01);
        drive(sel3, g, 2'b00);
    endtask

    task automatic exit_pass(input bit sel3, input int g);
        drive(sel3, g, 2'b01);
        drive(sel3, g, 2'b11);
        drive(sel3, g, 2'b10);
        drive(sel3, g, 2'b00);
    endtask

    initial begin
        reset   = 1'b1;
        sens_a  = '0;
        sens_b  = '0;
        sens_a3 = '0;
        sens_b3 = '0;
        repeat (2) tick();

        // Reset state
        check("rst count",  count, 0);
        check("rst empty",  empty, 1);
        check("rst full",   full, 0);
        check("rst pulses", {entry_pulse, exit_pulse, reject_pulse}, 0);
        reset = 1'b0;

        // Simultaneous passes at CAPACITY=3
        entry_pass(1'b1, 0);
        entry_pass(1'b1, 0);
        check("cap3 count2", count3, 2);
        sens_a3 = 2'b11; sens_b3 = 2'b00; tick();
        sens_a3 = 2'b11; sens_b3 = 2'b11; tick();
        sens_a3 = 2'b00; sens_b3 = 2'b11; tick();
        sens_a3 = 2'b00; sens_b3 = 2'b00; tick();
        check("cap3 dual entry_pulse",  entry_pulse3, 2'b01);
        check("cap3 dual reject_pulse", reject_pulse3, 2'b10);
        check("cap3 dual count",        count3, 3);
        check("cap3 full",              full3, 1);
        // gate0 entering while gate1 exits
        sens_a3 = 2'b01; sens_b3 = 2'b10; tick();
        sens_a3 = 2'b11; sens_b3 = 2'b11; tick();
        sens_a3 = 2'b10; sens_b3 = 2'b01; tick();
        sens_a3 = 2'b00; sens_b3 = 2'b00; tick();
        check("cap3 mix entry_pulse",  entry_pulse3, 2'b01);
        check("cap3 mix exit_pulse",   exit_pulse3, 2'b10);
        check("cap3 mix reject_pulse", reject_pulse3, 2'b00);
        check("cap3 mix count",        count3, 3);

        // Fill the main instance to 40 through gate0
        for (int i = 1; i <= 40; i++) begin
            entry_pass(1'b0, 0);
            check("fill count", count, 32'(i));
            check("fill entry_pulse", entry_pulse, 2'b01);
        end
        check("fill full", full, 1);
        entry_pass(1'b0, 0);
        check("fill41 reject_pulse", reject_pulse, 2'b01);
        check("fill41 entry_pulse",  entry_pulse, 2'b00);
        check("fill41 count",        count, 40);
        tick();
        check("pulse one cycle", reject_pulse, 2'b00);

        // Drain through gate1
        for (int i = 1; i <= 40; i++) begin
            exit_pass(1'b0, 1);
            check("drain count", count, 32'(40 - i));
        end
        check("drain empty", empty, 1);
        check("drain full",  full, 0);
        exit_pass(1'b0, 1);
        check("drain41 reject_pulse", reject_pulse, 2'b10);
        check("drain41 exit_pulse",   exit_pulse, 2'b00);
        check("drain41 count",        count, 0);

        // Dwell: 00,10,11,11,01,00
        drive(1'b0, 0, 2'b00);
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b11);
        drive(1'b0, 0, 2'b11);
        drive(1'b0, 0, 2'b01);
        drive(1'b0, 0, 2'b00);
        check("dwell count", count, 1);
        // Backtrack: 00,10,11,10,11,01,00
        drive(1'b0, 0, 2'b00);
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b11);
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b11);
        drive(1'b0, 0, 2'b01);
        drive(1'b0, 0, 2'b00);
        check("backtrack count", count, 2);
        // Abandoned: 00,10,00
        drive(1'b0, 0, 2'b00);
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b00);
        check("abandon count",       count, 2);
        check("abandon entry_pulse", entry_pulse, 2'b00);

        // Illegal: 10 then 01 on gate0
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b01);
`ifdef PARK_GATE_ERR_EN
        check("illegal gate_err", gate_err, 2'b01);
`endif
        drive(1'b0, 0, 2'b00);
`ifdef PARK_GATE_ERR_EN
        check("illegal gate_err clears", gate_err, 2'b00);
`endif
        check("illegal count", count, 2);
        check("illegal pulses", {entry_pulse, exit_pulse, reject_pulse}, 0);

        // Reset during EN2 at count 5
        for (int i = 0; i < 3; i++) entry_pass(1'b0, 0);
        check("pre-reset count", count, 5);
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b11);
        reset = 1'b1;
        tick();
        check("mid reset count", count, 0);
        check("mid reset empty", empty, 1);
        reset = 1'b0;
        drive(1'b0, 0, 2'b01);
        drive(1'b0, 0, 2'b00);
        check("post reset count",  count, 0);
        check("post reset pulses", {entry_pulse, exit_pulse, reject_pulse}, 0);

        // Reset on the completing edge discards the entry
        drive(1'b0, 0, 2'b10);
        drive(1'b0, 0, 2'b11);
        drive(1'b0, 0, 2'b01);
        sens_a[0] = 1'b0;
        sens_b[0] = 1'b0;
        reset = 1'b1;
        tick();
        check("reset dominates count", count, 0);
        check("reset dominates pulse", entry_pulse, 2'b00);
        reset = 1'b0;
        tick();
        check("after reset idle count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
